// File: rtl/mandelbrot_coord_gen.sv
// mandelbrot_coord_gen: raster-scans the screen and streams one complex
// coordinate (cx, cy) plus its linear pixel address per pixel over a
// valid/ready interface. The start point and steps are latched at frame start.
// Optional macro MANDELBROT_COORD_ABORT_EN adds an abort input that ends a
// frame early, with no done pulse.
module mandelbrot_coord_gen #(
   parameter int FPW   = 27,
   parameter int AW    = 19,
   parameter int CW    = 12,
   parameter int VMINX = 0,
   parameter int VMAXX = 639,
   parameter int VMINY = 0,
   parameter int VMAXY = 479
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clk_en,
   input  logic                  en,
   input  logic signed [FPW-1:0] x0,
   input  logic signed [FPW-1:0] y0,
   input  logic signed [FPW-1:0] incx,
   input  logic signed [FPW-1:0] incy,
`ifdef MANDELBROT_COORD_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic signed [FPW-1:0] out_x,
   output logic signed [FPW-1:0] out_y,
   output logic [AW-1:0]         out_adr
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CW-1:0] MINX   = CW'(VMINX);
   localparam logic [CW-1:0] MAXX   = CW'(VMAXX);
   localparam logic [CW-1:0] MINY   = CW'(VMINY);
   localparam logic [CW-1:0] MAXY   = CW'(VMAXY);
   localparam logic [CW-1:0] CNT1   = CW'(1);
   localparam logic [AW-1:0] ADR1   = AW'(1);

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  vld_q, vld_d;
   logic signed [FPW-1:0] x_q, x_d;
   logic signed [FPW-1:0] y_q, y_d;
   logic [AW-1:0]         adr_q, adr_d;
   logic [CW-1:0]         cx_q, cx_d;
   logic [CW-1:0]         cy_q, cy_d;
   logic signed [FPW-1:0] x0_q, x0_d;
   logic signed [FPW-1:0] incx_q, incx_d;
   logic signed [FPW-1:0] incy_q, incy_d;
   logic                  xfer;
   logic                  abort_w;

`ifdef MANDELBROT_COORD_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // clk_en gating lives in the register block, so a transfer here is vld && rdy
   assign xfer = vld_q && out_rdy;

   // Next-state computation for the scan FSM and coordinate datapath
   always_comb begin
      state_d = state_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      vld_d   = vld_q;
      x_d     = x_q;
      y_d     = y_q;
      adr_d   = adr_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      x0_d    = x0_q;
      incx_d  = incx_q;
      incy_d  = incy_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               x0_d    = x0;
               incx_d  = incx;
               incy_d  = incy;
               x_d     = x0;
               y_d     = y0;
               adr_d   = '0;
               cx_d    = MINX;
               cy_d    = MINY;
               vld_d   = 1'b1;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (xfer) begin
               adr_d = adr_q + ADR1;
               if (cx_q != MAXX) begin
                  x_d  = x_q + incx_q;
                  cx_d = cx_q + CNT1;
               end else if (cy_q != MAXY) begin
                  x_d  = x0_q;
                  y_d  = y_q + incy_q;
                  cx_d = MINX;
                  cy_d = cy_q + CNT1;
               end else begin
                  // last pixel accepted: hold coordinates, rewind counters
                  adr_d   = adr_q;
                  cx_d    = MINX;
                  cy_d    = MINY;
                  vld_d   = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = DONE;
               end
            end
            // abort still lets this cycle's transfer land, but suppresses done
            if (abort_w) begin
               cx_d    = MINX;
               cy_d    = MINY;
               vld_d   = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               state_d = IDLE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; everything freezes while clk_en is low
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         vld_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         adr_q   <= '0;
         cx_q    <= MINX;
         cy_q    <= MINY;
         x0_q    <= '0;
         incx_q  <= '0;
         incy_q  <= '0;
      end else if (clk_en) begin
         state_q <= state_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         vld_q   <= vld_d;
         x_q     <= x_d;
         y_q     <= y_d;
         adr_q   <= adr_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         x0_q    <= x0_d;
         incx_q  <= incx_d;
         incy_q  <= incy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign out_vld = vld_q;
   assign out_x   = x_q;
   assign out_y   = y_q;
   assign out_adr = adr_q;

endmodule
